// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: OPMODE words, FSM state encoding and default pipeline latency for the DSP48A1 MAC sequencer
package dsp_seq_pkg;
  localparam int LAT_DEF = 3;
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;
  localparam logic [7:0] OPM_BIAS  = 8'h0D;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACCUM = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_HOLD  = 2'd3;
endpackage

// File: rtl/dsp_seq_tag_pipe.sv
// dsp_seq_tag_pipe: DEPTH-stage shift register carrying {valid,last} tags in step with the slice pipeline
module dsp_seq_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out
);
  logic [1:0] sr [DEPTH];
  assign tag_out = sr[DEPTH-1];
  // shift tags one stage per cycle; reset empties the pipe so a discarded job leaves no tag behind
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) sr[i] <= 2'b00;
    else begin
      sr[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1 slice as a dot-product engine, one result per job; SEQ_BIAS_EN adds a per-job C-port bias
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_data,
  output logic [CNT_W-1:0] out_terms,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
`ifdef SEQ_BIAS_EN
  input  logic [47:0]      in_bias,
  output logic [47:0]      dsp_c,
`endif
  input  logic [47:0]      dsp_p
);
`ifdef SEQ_BIAS_EN
  localparam logic [7:0] FIRST_OP = OPM_BIAS;
`else
  localparam logic [7:0] FIRST_OP = OPM_FIRST;
`endif
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       slot_op;
  logic [1:0]       tag_q, tag_o;
  logic             acc, first, capture;
  assign in_ready = (state == S_IDLE || state == S_ACCUM) && !dsp_rst;
  assign acc      = in_valid && in_ready;
  assign first    = state == S_IDLE;
  assign capture  = state == S_DRAIN && tag_o == 2'b11;
  dsp_seq_tag_pipe #(.DEPTH(LAT)) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_q),
    .tag_out(tag_o)
  );
  // job FSM, saturating term counter and result capture when the last term's tag reaches DSP_P
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_terms <= '0;
    end else begin
      if (acc) begin
        state <= in_last ? S_DRAIN : S_ACCUM;
        cnt   <= first ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
      end
      if (capture) begin
        state     <= S_HOLD;
        out_valid <= 1'b1;
        out_data  <= dsp_p;
        out_terms <= cnt;
      end
      if (state == S_HOLD && out_ready) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
      end
    end
  // issue slot: operands and tag now, OPMODE one cycle later to match the slice's OPMODEREG/MREG timing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dsp_a      <= '0;
      dsp_b      <= '0;
      tag_q      <= 2'b00;
      slot_op    <= 8'h00;
      dsp_opmode <= 8'h00;
      dsp_ce     <= 1'b0;
      dsp_rst    <= 1'b1;
`ifdef SEQ_BIAS_EN
      dsp_c      <= '0;
`endif
    end else begin
      dsp_a      <= acc ? in_a : '0;
      dsp_b      <= acc ? in_b : '0;
      tag_q      <= {acc, acc && in_last};
      slot_op    <= acc ? (first ? FIRST_OP : OPM_ACC) : OPM_HOLD;
      dsp_opmode <= slot_op;
      dsp_ce     <= 1'b1;
      dsp_rst    <= 1'b0;
`ifdef SEQ_BIAS_EN
      if (acc && first) dsp_c <= in_bias;
`endif
    end
endmodule
